// File: rtl/alu_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// alu_regfile_ctrl
// Operand-fetch / write-back stage wrapped around the combinational alu_8bit.
// Holds a NREG x DW register file, accepts one instruction at a time over a
// valid/ready handshake, presents registered operands to the ALU, captures the
// ALU result and flags one cycle later, and writes the result back.
//
// Ports
//   clk, rst_n         rising-edge clock, synchronous active-low reset
//   in_valid/in_ready  instruction handshake (in_ready high only in IDLE)
//   in_load            1 = write in_imm to in_rd, 0 = ALU operation
//   in_op              ALU opcode (alu_8bit encoding)
//   in_rd/rs1/rs2      destination and source register addresses
//   in_imm             immediate for loads
//   alu_a/alu_b        registered operands to alu_8bit
//   alu_opcode         registered opcode to alu_8bit
//   alu_result/carry/zero  results from alu_8bit
//   out_valid          one-cycle completion pulse
//   out_data           written (or would-be) result
//   out_err            qualifies out_valid: instruction rejected
//   flag_c/flag_z      sticky flags from the last successful ALU op
//   dbg_addr/dbg_data  combinational register-file read port
// -----------------------------------------------------------------------------
module alu_regfile_ctrl #(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_load,
    input  logic [3:0]               in_op,
    input  logic [$clog2(NREG)-1:0]  in_rd,
    input  logic [$clog2(NREG)-1:0]  in_rs1,
    input  logic [$clog2(NREG)-1:0]  in_rs2,
    input  logic [DW-1:0]            in_imm,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [3:0]               alu_opcode,
    input  logic [DW-1:0]            alu_result,
    input  logic                     alu_carry,
    input  logic                     alu_zero,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic                     out_err,
    output logic                     flag_c,
    output logic                     flag_z,
    input  logic [$clog2(NREG)-1:0]  dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t          state_r;
    logic            in_ready_r;
    logic [DW-1:0]   regs_r [NREG];
    logic [DW-1:0]   res_r;
    logic            err_r;
    logic            c_r;
    logic            z_r;
    logic            is_load_r;
    logic [AW-1:0]   rd_r;
    logic [3:0]      op_r;

    // Opcodes that alu_8bit leaves undefined; such instructions are rejected.
    function automatic logic is_illegal_op(input logic [3:0] op);
        case (op)
            4'b0101, 4'b0110, 4'b0111, 4'b1100, 4'b1101: is_illegal_op = 1'b1;
            default:                                     is_illegal_op = 1'b0;
        endcase
    endfunction

    // Divide (1111) by a zero divisor is rejected as well.
    function automatic logic is_div_by_zero(input logic [3:0] op, input logic [DW-1:0] divisor);
        is_div_by_zero = (op == 4'b1111) && (divisor == {DW{1'b0}});
    endfunction

    assign in_ready = in_ready_r;
    assign dbg_data = regs_r[dbg_addr];

    // Control FSM, register file, ALU operand registers and completion outputs.
    // out_valid/out_data/out_err are loaded on the edge that enters WB so the
    // pulse coincides with the WB cycle; the register write lands at the end
    // of WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
            alu_a      <= {DW{1'b0}};
            alu_b      <= {DW{1'b0}};
            alu_opcode <= 4'd0;
            out_valid  <= 1'b0;
            out_data   <= {DW{1'b0}};
            out_err    <= 1'b0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            res_r      <= {DW{1'b0}};
            err_r      <= 1'b0;
            c_r        <= 1'b0;
            z_r        <= 1'b0;
            is_load_r  <= 1'b0;
            rd_r       <= {AW{1'b0}};
            op_r       <= 4'd0;
        end else begin
            // Completion outputs are pulses; out_err never outlives out_valid.
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        rd_r       <= in_rd;
                        in_ready_r <= 1'b0;
                        if (in_load) begin
                            // Loads skip EXEC and leave the ALU ports untouched.
                            is_load_r <= 1'b1;
                            res_r     <= in_imm;
                            err_r     <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= in_imm;
                            out_err   <= 1'b0;
                            state_r   <= ST_WB;
                        end else begin
                            // Operands are sampled here, so rd==rs reads the old value.
                            is_load_r  <= 1'b0;
                            op_r       <= in_op;
                            alu_a      <= regs_r[in_rs1];
                            alu_b      <= regs_r[in_rs2];
                            alu_opcode <= in_op;
                            state_r    <= ST_EXEC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    res_r     <= alu_result;
                    c_r       <= alu_carry;
                    z_r       <= alu_zero;
                    err_r     <= is_illegal_op(op_r) | is_div_by_zero(op_r, alu_b);
                    out_valid <= 1'b1;
                    out_data  <= alu_result;
                    out_err   <= is_illegal_op(op_r) | is_div_by_zero(op_r, alu_b);
                    state_r   <= ST_WB;
                end
                ST_WB: begin
                    if (!err_r) begin
                        regs_r[rd_r] <= res_r;
                    end else begin
                        regs_r[rd_r] <= regs_r[rd_r];
                    end
                    if (!err_r && !is_load_r) begin
                        flag_c <= c_r;
                        flag_z <= z_r;
                    end else begin
                        flag_c <= flag_c;
                        flag_z <= flag_z;
                    end
                    in_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    in_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_regfile_ctrl
// Self-checking bench for alu_regfile_ctrl. A behavioural stand-in for
// alu_8bit answers the DUT's ALU ports; a register-file/flag model predicts
// every completion, write-back and flag update from instruction semantics.
// -----------------------------------------------------------------------------
module tb_alu_regfile_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [3:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;
    logic [7:0] in_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_zero;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_err;
    logic       flag_c;
    logic       flag_z;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int tests_run;
    int tests_failed;

    // Reference state
    logic [7:0] m_regs [4];
    logic       m_c;
    logic       m_z;

    alu_regfile_ctrl #(.DW(8), .NREG(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_err    (out_err),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural alu_8bit: {carry, result}
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        case (op)
            4'b0000: alu_ref = {1'b0, a} + {1'b0, b};
            4'b0001: alu_ref = {1'b0, a} - {1'b0, b};
            4'b0010: alu_ref = {1'b0, a & b};
            4'b0011: alu_ref = {1'b0, a | b};
            4'b0100: alu_ref = {1'b0, a ^ b};
            4'b1000: alu_ref = {a[7], a[6:0], 1'b0};
            4'b1001: alu_ref = {a[0], 1'b0, a[7:1]};
            4'b1010: alu_ref = {1'b0, ~a};
            4'b1011: alu_ref = {1'b0, a} + 9'd1;
            4'b1110: begin
                prod    = a * b;
                alu_ref = {|prod[15:8], prod[7:0]};
            end
            4'b1111: alu_ref = (b == 8'd0) ? 9'h0FF : {1'b0, a / b};
            default: alu_ref = 9'd0;
        endcase
    endfunction

    function automatic bit op_rejected(input logic [3:0] op, input logic [7:0] b);
        op_rejected = (op inside {4'b0101, 4'b0110, 4'b0111, 4'b1100, 4'b1101}) ||
                      (op == 4'b1111 && b == 8'd0);
    endfunction

    // ALU stand-in driven by the DUT's registered operands.
    always_comb begin
        logic [8:0] r;
        r          = alu_ref(alu_opcode, alu_a, alu_b);
        alu_result = r[7:0];
        alu_carry  = r[8];
        alu_zero   = (r[7:0] == 8'd0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            check_eq($sformatf("%s_r%0d", tag, i), dbg_data, m_regs[i]);
        end
    endtask

    task automatic scramble_inputs();
        in_load = 1'($urandom);
        in_op   = 4'($urandom);
        in_rd   = 2'($urandom);
        in_rs1  = 2'($urandom);
        in_rs2  = 2'($urandom);
        in_imm  = 8'($urandom);
    endtask

    // Issue one instruction from IDLE (time = just after a posedge) and check it.
    task automatic run_instr(input bit ld, input logic [3:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
        logic [7:0] exp_data;
        logic [8:0] r;
        bit         exp_err;
        int         exp_lat;
        int         lat;
        int         n;
        if (ld) begin
            exp_data = imm;
            exp_err  = 1'b0;
            exp_lat  = 1;
            r        = 9'd0;
        end else begin
            r        = alu_ref(op, m_regs[rs1], m_regs[rs2]);
            exp_data = r[7:0];
            exp_err  = op_rejected(op, m_regs[rs2]);
            exp_lat  = 2;
        end
        in_load  = ld;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        lat = 1;
        while (!out_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("out_data", out_data, exp_data);
        check_eq("out_err", out_err, exp_err);
        if (!exp_err) m_regs[rd] = exp_data;
        if (!exp_err && !ld) begin
            m_c = r[8];
            m_z = (r[7:0] == 8'd0);
        end
        @(posedge clk); #1;
        check_eq("pulse_end", out_valid, 0);
        check_eq("err_idle", out_err, 0);
        check_eq("ready_back", in_ready, 1);
        check_eq("flag_c", flag_c, m_c);
        check_eq("flag_z", flag_z, m_z);
        check_regs("regs");
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 8'd0;
        m_c = 1'b0;
        m_z = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [8:0] r;
        bit         e;
        tests_run    = 0;
        tests_failed = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dbg_addr = 2'd0;
        scramble_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check_eq("rst_ready", in_ready, 1);
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_err", out_err, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_alu_a", alu_a, 0);
        check_eq("rst_alu_b", alu_b, 0);
        check_eq("rst_alu_op", alu_opcode, 0);
        check_eq("rst_flags", {flag_c, flag_z}, 0);
        check_regs("rst");
        @(posedge clk); #1;

        // Directed sequence
        run_instr(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 8'h0F);
        run_instr(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 8'h01);
        run_instr(1'b0, 4'b0000, 2'd2, 2'd0, 2'd1, 8'h00);
        dbg_addr = 2'd2; #1;
        check_eq("add_r2_const", dbg_data, 8'h10);
        run_instr(1'b0, 4'b0001, 2'd3, 2'd1, 2'd1, 8'h00);
        check_eq("sub_z_const", flag_z, 1);
        run_instr(1'b1, 4'd0, 2'd3, 2'd0, 2'd0, 8'hAA);
        check_eq("load_keeps_z", flag_z, 1);
        run_instr(1'b0, 4'b0101, 2'd0, 2'd1, 2'd2, 8'h00);
        dbg_addr = 2'd0; #1;
        check_eq("illegal_r0_const", dbg_data, 8'h0F);
        run_instr(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 8'h00);
        run_instr(1'b0, 4'b1111, 2'd2, 2'd0, 2'd1, 8'h00);
        run_instr(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 8'h02);
        run_instr(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 8'h08);
        run_instr(1'b0, 4'b1111, 2'd2, 2'd0, 2'd1, 8'h00);
        dbg_addr = 2'd2; #1;
        check_eq("div_r2_const", dbg_data, 8'h04);
        // rd aliasing a source: operands are the pre-write values
        run_instr(1'b0, 4'b0000, 2'd0, 2'd0, 2'd0, 8'h00);

        // Back-to-back ALU ops with in_valid held high
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            op  = 4'($urandom);
            rd  = 2'($urandom);
            rs1 = 2'($urandom);
            rs2 = 2'($urandom);
            r   = alu_ref(op, m_regs[rs1], m_regs[rs2]);
            e   = op_rejected(op, m_regs[rs2]);
            in_load = 1'b0;
            in_op   = op;
            in_rd   = rd;
            in_rs1  = rs1;
            in_rs2  = rs2;
            check_eq("b2b_ready_idle", in_ready, 1);
            @(posedge clk); #1;
            scramble_inputs();
            check_eq("b2b_ready_exec", in_ready, 0);
            check_eq("b2b_early_valid", out_valid, 0);
            @(posedge clk); #1;
            check_eq("b2b_ready_wb", in_ready, 0);
            check_eq("b2b_valid", out_valid, 1);
            check_eq("b2b_data", out_data, r[7:0]);
            check_eq("b2b_err", out_err, e);
            if (!e) begin
                m_regs[rd] = r[7:0];
                m_c = r[8];
                m_z = (r[7:0] == 8'd0);
            end
            @(posedge clk); #1;
            check_eq("b2b_single_pulse", out_valid, 0);
        end
        in_valid = 1'b0;
        check_regs("b2b");
        check_eq("b2b_flags", {flag_c, flag_z}, {m_c, m_z});
        @(posedge clk); #1;

        // Randomized instruction mix
        for (int k = 0; k < 60; k++) begin
            run_instr(($urandom_range(0, 2) == 0), 4'($urandom), 2'($urandom), 2'($urandom),
                      2'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
        end

        // Reset during EXEC of an add targeting R2
        run_instr(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 8'h55);
        in_load  = 1'b0;
        in_op    = 4'b0000;
        in_rd    = 2'd2;
        in_rs1   = 2'd0;
        in_rs2   = 2'd1;
        in_valid = 1'b1;
        check_eq("rstx_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        check_eq("rstx_no_valid", out_valid, 0);
        rst_n = 1'b1;
        model_reset();
        check_eq("rstx_ready_after", in_ready, 1);
        check_eq("rstx_flags", {flag_c, flag_z}, 0);
        check_regs("rstx");
        @(posedge clk); #1;
        check_eq("rstx_still_no_valid", out_valid, 0);
        run_instr(1'b1, 4'd0, 2'd3, 2'd0, 2'd0, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
